perceptron_feeder: RTL and testbench



---
 rtl/perceptron_feeder.sv | 141 ++++++++++++++
 tb/tb_perceptron_feeder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/perceptron_feeder.sv
// Parses the input byte stream into weight/bias/feature commands and feeds features to the perceptron.
// A feature is visible one edge after its push; in FEAT, in_ready drops while the feature FIFO is full.
module perceptron_feeder #(
    parameter int N_WEIGHTS  = 7,
    parameter int W          = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [W-1:0]           in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [W-1:0]           feat_data,
    output logic                   feat_valid,
    input  logic                   feat_ready,
    output logic [N_WEIGHTS*W-1:0] weights_flat,
    output logic [W-1:0]           bias,
    output logic                   cfg_busy,
    output logic [3:0]             cfg_epoch,
    output logic                   err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = (N_WEIGHTS > 1) ? $clog2(N_WEIGHTS) : 1;

    typedef enum logic [1:0] {IDLE, WLOAD, BLOAD, FEAT} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx;
    logic [W-1:0]  shadow [N_WEIGHTS];
    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [AW:0]   wptr, rptr;

    logic          accept, fifo_full, push, pop;
    logic          flush, hdr_bad, commit, bias_wr, wl_start;
    logic [1:0]    op;
    logic [W-3:0]  arg;

    assign op         = in_data[W-1 -: 2];
    assign arg        = in_data[W-3:0];
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign feat_valid = (wptr != rptr);
    assign feat_data  = mem[rptr[AW-1:0]];
    assign in_ready   = (state == FEAT) ? !fifo_full : 1'b1;
    assign accept     = in_valid && in_ready;
    assign pop        = feat_valid && feat_ready;
    assign cfg_busy   = (state == WLOAD);

    always_comb begin
        state_nxt = state;
        flush     = 1'b0;
        hdr_bad   = 1'b0;
        commit    = 1'b0;
        bias_wr   = 1'b0;
        push      = 1'b0;
        wl_start  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op)
                        2'b00: begin
                            if (arg == (W-2)'(N_WEIGHTS)) begin
                                state_nxt = WLOAD;
                                wl_start  = 1'b1;
                            end else begin
                                hdr_bad = 1'b1;
                            end
                        end
                        2'b01:   state_nxt = BLOAD;
                        2'b10:   state_nxt = FEAT;
                        default: flush = 1'b1;
                    endcase
                end
            end
            WLOAD: begin
                if (accept && idx == IW'(N_WEIGHTS-1)) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            BLOAD: begin
                if (accept) begin
                    bias_wr   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            FEAT: begin
                if (accept) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            bias      <= '0;
            cfg_epoch <= 4'd0;
            err       <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            for (int i = 0; i < N_WEIGHTS; i++)
                weights_flat[i*W +: W] <= {1'b1, {(W-1){1'b0}}};
        end else begin
            state <= state_nxt;
            if (wl_start)
                idx <= '0;
            else if (state == WLOAD && accept)
                idx <= idx + IW'(1);
            // Last byte bypasses the shadow so the whole frame lands on one edge.
            if (commit) begin
                for (int i = 0; i < N_WEIGHTS; i++)
                    weights_flat[i*W +: W] <= (IW'(i) == idx) ? in_data : shadow[i];
            end
            if (bias_wr)
                bias <= in_data;
            if (commit || bias_wr)
                cfg_epoch <= cfg_epoch + 4'd1;
            if (hdr_bad)
                err <= 1'b1;
            else if (flush)
                err <= 1'b0;
            if (flush)
                rptr <= wptr;
            else if (pop)
                rptr <= rptr + (AW+1)'(1);
            if (push)
                wptr <= wptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (state == WLOAD && accept)
            shadow[idx] <= in_data;
        if (push)
            mem[wptr[AW-1:0]] <= in_data;
    end
endmodule

// File: tb/tb_perceptron_feeder.sv
// Directed bench for perceptron_feeder: inputs driven and outputs sampled on the falling edge.
module tb_perceptron_feeder;
    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  feat_data;
    logic        feat_valid;
    logic        feat_ready;
    logic [55:0] weights_flat;
    logic [7:0]  bias;
    logic        cfg_busy;
    logic [3:0]  cfg_epoch;
    logic        err;

    int checks = 0;
    int errors = 0;

    perceptron_feeder #(.N_WEIGHTS(7), .W(8), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .feat_data(feat_data), .feat_valid(feat_valid), .feat_ready(feat_ready),
        .weights_flat(weights_flat), .bias(bias),
        .cfg_busy(cfg_busy), .cfg_epoch(cfg_epoch), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the byte was accepted.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed in_ready=0 for %0d cycles expected 1", n);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic gap();
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        feat_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_weights", 64'(weights_flat), 64'h80808080808080);
        chk("rst_bias", 64'(bias), 64'h00);
        chk("rst_feat_valid", 64'(feat_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_epoch", 64'(cfg_epoch), 64'd0);
        chk("rst_busy", 64'(cfg_busy), 64'd0);

        // Weight frame with gaps between bytes
        send(8'h07);
        chk("wl_busy_hdr", 64'(cfg_busy), 64'd1);
        for (int k = 1; k <= 6; k++) begin
            gap();
            send(8'(k));
        end
        chk("wl_partial_weights", 64'(weights_flat), 64'h80808080808080);
        chk("wl_busy_partial", 64'(cfg_busy), 64'd1);
        chk("wl_epoch_partial", 64'(cfg_epoch), 64'd0);
        send(8'h07);
        chk("wl_commit_weights", 64'(weights_flat), 64'h07060504030201);
        chk("wl_busy_done", 64'(cfg_busy), 64'd0);
        chk("wl_epoch", 64'(cfg_epoch), 64'd1);

        // Bad weight-load length, bias load, abort clears err
        send(8'h05);
        chk("bad_hdr_err", 64'(err), 64'd1);
        chk("bad_hdr_busy", 64'(cfg_busy), 64'd0);
        send(8'h40);
        send(8'hF6);
        chk("bias_val", 64'(bias), 64'hF6);
        chk("bias_epoch", 64'(cfg_epoch), 64'd2);
        chk("bias_weights_kept", 64'(weights_flat), 64'h07060504030201);
        send(8'hC0);
        chk("abort_err_clr", 64'(err), 64'd0);
        chk("abort_epoch_kept", 64'(cfg_epoch), 64'd2);
        chk("abort_bias_kept", 64'(bias), 64'hF6);

        // Fill FIFO with the consumer stalled
        send(8'h80);
        send(8'hA5);
        chk("fifo_one_valid", 64'(feat_valid), 64'd1);
        chk("fifo_one_head", 64'(feat_data), 64'hA5);
        send(8'h80);
        send(8'h3C);
        send(8'h80);
        chk("fifo_full_in_ready", 64'(in_ready), 64'd0);
        chk("fifo_full_head", 64'(feat_data), 64'hA5);
        in_data  = 8'h5A;
        in_valid = 1'b1;
        @(negedge clk);
        chk("fifo_stall_in_ready", 64'(in_ready), 64'd0);
        chk("fifo_stall_head", 64'(feat_data), 64'hA5);

        // Pop while full with a pending push: push stalls one cycle, then enters
        feat_ready = 1'b1;
        chk("full_pop_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("pop1_data", 64'(feat_data), 64'h3C);
        chk("pop1_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pop2_data", 64'(feat_data), 64'h5A);
        chk("pop2_valid", 64'(feat_valid), 64'd1);
        @(negedge clk);
        chk("drained_valid", 64'(feat_valid), 64'd0);
        chk("drained_in_ready", 64'(in_ready), 64'd1);

        // Flush coinciding with a pop empties the FIFO
        feat_ready = 1'b0;
        send(8'h80);
        send(8'h11);
        send(8'h80);
        send(8'h22);
        chk("pre_flush_head", 64'(feat_data), 64'h11);
        feat_ready = 1'b1;
        send(8'hC0);
        feat_ready = 1'b0;
        chk("flush_valid", 64'(feat_valid), 64'd0);
        send(8'h80);
        send(8'h77);
        chk("post_flush_head", 64'(feat_data), 64'h77);
        chk("post_flush_valid", 64'(feat_valid), 64'd1);

        // Reset in the middle of a weight frame
        send(8'h07);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_weights", 64'(weights_flat), 64'h80808080808080);
        chk("midrst_epoch", 64'(cfg_epoch), 64'd0);
        chk("midrst_busy", 64'(cfg_busy), 64'd0);
        chk("midrst_fifo", 64'(feat_valid), 64'd0);
        chk("midrst_bias", 64'(bias), 64'h00);
        // 0xC0 inside WLOAD is weight data, not an abort
        send(8'h07);
        send(8'hC0);
        for (int k = 1; k <= 5; k++) send(8'(k));
        chk("frame2_partial", 64'(weights_flat), 64'h80808080808080);
        send(8'h06);
        chk("frame2_weights", 64'(weights_flat), 64'h060504030201C0);
        chk("frame2_epoch", 64'(cfg_epoch), 64'd1);
        chk("frame2_busy", 64'(cfg_busy), 64'd0);

        // Epoch wraps 15 -> 0
        for (int k = 1; k <= 15; k++) begin
            send(8'h40);
            send(8'(k));
        end
        chk("wrap_epoch", 64'(cfg_epoch), 64'd0);
        chk("wrap_bias", 64'(bias), 64'h0F);
        chk("wrap_weights_kept", 64'(weights_flat), 64'h060504030201C0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
